// File: rtl/jtbubl_pkg.sv
// Shared definitions for the Bubble Bobble main/sound CPU command link:
// sound-side register map, NMI sequencer states and the status byte layout.
package jtbubl_pkg;

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_NMI_ON  = 2'd1;
   localparam logic [1:0] REG_NMI_OFF = 2'd2;
   localparam logic [1:0] REG_OVF_CLR = 2'd3;

   localparam logic [7:0] EMPTY_BYTE  = 8'hFF;

   typedef enum logic [1:0] {
      NMI_IDLE  = 2'd0,
      NMI_PULSE = 2'd1,
      NMI_WAIT  = 2'd2
   } nmi_state_e;

   function automatic logic [7:0] status_byte(input logic ovf,
                                              input logic main_flag,
                                              input logic snd_flag);
      return {5'b0, ovf, main_flag, snd_flag};
   endfunction

endpackage

// File: rtl/jtbubl_sndcomm_fifo.sv
// Command FIFO from main CPU to sound CPU; head is read combinationally so the
// sound CPU sees stable data for the whole access, flags are registered.
module jtbubl_sndcomm_fifo
   import jtbubl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic [7:0] din_i,
   output logic [7:0] head_o,
   output logic       nempty_o,
   output logic       full_o,
   output logic       drop_o
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          nempty_q, full_q;
   logic          push_ok, pop_ok;

   // A push into a full FIFO is still accepted when a pop frees a slot this cycle.
   always_comb begin
      pop_ok   = pop_i && (cnt_q != '0);
      push_ok  = push_i && ((cnt_q != FULL_CNT) || pop_ok);
      drop_o   = push_i && !push_ok;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)
         cnt_d = cnt_q + (AW+1)'(1);
      else if (pop_ok && !push_ok)
         cnt_d = cnt_q - (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         nempty_q <= 1'b0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         nempty_q <= (cnt_d != '0);
         full_q   <= (cnt_d == FULL_CNT);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

   assign head_o   = nempty_q ? mem_q[rd_ptr_q] : EMPTY_BYTE;
   assign nempty_o = nempty_q;
   assign full_o   = full_q;

endmodule

// File: rtl/jtbubl_sndcomm.sv
// Main-to-sound CPU communication block: command FIFO, reply latch, sound-side
// register decode and an NMI sequencer that interrupts the sound Z80 per command.
module jtbubl_sndcomm
   import jtbubl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int NMI_W = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       main_wr,
   input  logic [7:0] main_din,
   input  logic       main_rd,
   output logic [7:0] main_dout,
   output logic       main_flag,
   output logic       snd_flag,
   output logic       fifo_full,
   input  logic       snd_cs,
   input  logic       snd_rd_n,
   input  logic       snd_wr_n,
   input  logic [1:0] snd_addr,
   input  logic [7:0] snd_din,
   output logic [7:0] snd_dout,
   output logic       nmi_n
);

   localparam int            CW      = (NMI_W > 1) ? $clog2(NMI_W) : 1;
   localparam logic [CW-1:0] PW_LAST = CW'(NMI_W - 1);

   logic       rd_now, wr_now;
   logic       rd_prev_q, wr_prev_q;
   logic       rd_start, rd_end, wr_start;
   logic       pop_arm_q, pop_arm_d;
   logic       pop;
   logic [7:0] head;
   logic       drop;
   logic [7:0] main_dout_q, main_dout_d;
   logic       main_flag_q, main_flag_d;
   logic       nmi_en_q, nmi_en_d;
   logic       ovf_q, ovf_d;
   nmi_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic       nmi_n_q, nmi_n_d;

   assign rd_now   = snd_cs && !snd_rd_n;
   assign wr_now   = snd_cs && !snd_wr_n;
   assign rd_start = rd_now && !rd_prev_q;
   assign wr_start = wr_now && !wr_prev_q;
   assign rd_end   = rd_prev_q && !rd_now;
   assign pop      = rd_end && pop_arm_q;

   jtbubl_sndcomm_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_i   (main_wr),
      .pop_i    (pop),
      .din_i    (main_din),
      .head_o   (head),
      .nempty_o (snd_flag),
      .full_o   (fifo_full),
      .drop_o   (drop)
   );

   // Pop is armed at the start of a data read that actually returned a command,
   // and fires once the Z80 lets go of the access.
   always_comb begin
      pop_arm_d = pop_arm_q;
      if (rd_start)
         pop_arm_d = (snd_addr == REG_DATA) && snd_flag;
      else if (rd_end)
         pop_arm_d = 1'b0;
   end

   always_comb begin
      main_dout_d = main_dout_q;
      main_flag_d = main_flag_q;
      nmi_en_d    = nmi_en_q;
      ovf_d       = ovf_q;
      if (main_rd) main_flag_d = 1'b0;
      if (wr_start) begin
         case (snd_addr)
            REG_DATA: begin
               main_dout_d = snd_din;
               main_flag_d = 1'b1;
            end
            REG_NMI_ON:  nmi_en_d = 1'b1;
            REG_NMI_OFF: nmi_en_d = 1'b0;
            REG_OVF_CLR: ovf_d    = 1'b0;
            default: ;
         endcase
      end
      if (drop) ovf_d = 1'b1;
   end

   // A pending command that is being popped this very cycle must not start a pulse.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      nmi_n_d = 1'b1;
      case (state_q)
         NMI_IDLE: begin
            if (nmi_en_q && snd_flag && !pop) begin
               state_d = NMI_PULSE;
               cnt_d   = '0;
               nmi_n_d = 1'b0;
            end
         end
         NMI_PULSE: begin
            if (cnt_q == PW_LAST) begin
               state_d = NMI_WAIT;
            end else begin
               cnt_d   = cnt_q + CW'(1);
               nmi_n_d = 1'b0;
            end
         end
         NMI_WAIT: begin
            if (pop) state_d = NMI_IDLE;
         end
         default: state_d = NMI_IDLE;
      endcase
      if (!nmi_en_d) begin
         state_d = NMI_IDLE;
         nmi_n_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_prev_q   <= 1'b0;
         wr_prev_q   <= 1'b0;
         pop_arm_q   <= 1'b0;
         main_dout_q <= 8'h00;
         main_flag_q <= 1'b0;
         nmi_en_q    <= 1'b0;
         ovf_q       <= 1'b0;
         state_q     <= NMI_IDLE;
         cnt_q       <= '0;
         nmi_n_q     <= 1'b1;
      end else begin
         rd_prev_q   <= rd_now;
         wr_prev_q   <= wr_now;
         pop_arm_q   <= pop_arm_d;
         main_dout_q <= main_dout_d;
         main_flag_q <= main_flag_d;
         nmi_en_q    <= nmi_en_d;
         ovf_q       <= ovf_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         nmi_n_q     <= nmi_n_d;
      end
   end

   always_comb begin
      case (snd_addr)
         REG_DATA:   snd_dout = head;
         REG_NMI_ON: snd_dout = status_byte(ovf_q, main_flag_q, snd_flag);
         default:    snd_dout = EMPTY_BYTE;
      endcase
   end

   assign main_dout = main_dout_q;
   assign main_flag = main_flag_q;
   assign nmi_n     = nmi_n_q;

endmodule

// File: tb/tb_jtbubl_sndcomm.sv
// Self-checking bench for jtbubl_sndcomm: directed scenarios plus a randomized
// mix of main/sound accesses compared against a queue-based reference model.
module tb_jtbubl_sndcomm;

   localparam int DEPTH = 4;
   localparam int NMI_W = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       main_wr = 1'b0, main_rd = 1'b0;
   logic [7:0] main_din = 8'h00;
   logic       snd_cs = 1'b0, snd_rd_n = 1'b1, snd_wr_n = 1'b1;
   logic [1:0] snd_addr = 2'd0;
   logic [7:0] snd_din = 8'h00;
   logic [7:0] main_dout, snd_dout;
   logic       main_flag, snd_flag, fifo_full, nmi_n;

   int chk_cnt = 0;
   int pass_cnt = 0;
   int nmi_low_total = 0;

   // reference model state
   logic [7:0] q_m[$];
   logic       ovf_m = 1'b0;
   logic       mflag_m = 1'b0;
   logic [7:0] mdout_m = 8'h00;

   jtbubl_sndcomm #(
      .DEPTH (DEPTH),
      .NMI_W (NMI_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .main_wr   (main_wr),
      .main_din  (main_din),
      .main_rd   (main_rd),
      .main_dout (main_dout),
      .main_flag (main_flag),
      .snd_flag  (snd_flag),
      .fifo_full (fifo_full),
      .snd_cs    (snd_cs),
      .snd_rd_n  (snd_rd_n),
      .snd_wr_n  (snd_wr_n),
      .snd_addr  (snd_addr),
      .snd_din   (snd_din),
      .snd_dout  (snd_dout),
      .nmi_n     (nmi_n)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && nmi_n === 1'b0) nmi_low_total++;
   end

   function automatic logic [7:0] model_read(input logic [1:0] a);
      if (a == 2'd0) return (q_m.size() != 0) ? q_m[0] : 8'hFF;
      if (a == 2'd1) return {5'b0, ovf_m, mflag_m, q_m.size() != 0};
      return 8'hFF;
   endfunction

   function automatic void model_push(input logic [7:0] b);
      if (q_m.size() < DEPTH) q_m.push_back(b);
      else ovf_m = 1'b1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      main_wr = 1'b1;
      main_din = b;
      tick();
      main_wr = 1'b0;
      model_push(b);
   endtask

   task automatic main_read();
      main_rd = 1'b1;
      tick();
      main_rd = 1'b0;
      mflag_m = 1'b0;
   endtask

   // Two-cycle Z80 read; optionally a main push lands on the cycle the pop happens.
   task automatic snd_read(input logic [1:0] a, input logic wr_at_pop,
                           input logic [7:0] pb, output logic [7:0] d);
      snd_cs = 1'b1;
      snd_addr = a;
      snd_rd_n = 1'b0;
      #1;
      d = snd_dout;
      tick();
      tick();
      snd_cs = 1'b0;
      snd_rd_n = 1'b1;
      main_wr = wr_at_pop;
      main_din = pb;
      tick();
      main_wr = 1'b0;
      if (a == 2'd0 && q_m.size() != 0) void'(q_m.pop_front());
      if (wr_at_pop) model_push(pb);
   endtask

   task automatic snd_write(input logic [1:0] a, input logic [7:0] d, input logic with_rd);
      snd_cs = 1'b1;
      snd_addr = a;
      snd_din = d;
      snd_wr_n = 1'b0;
      main_rd = with_rd;
      tick();
      main_rd = 1'b0;
      tick();
      snd_cs = 1'b0;
      snd_wr_n = 1'b1;
      tick();
      if (with_rd) mflag_m = 1'b0;
      if (a == 2'd0) begin
         mdout_m = d;
         mflag_m = 1'b1;
      end
      if (a == 2'd3) ovf_m = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      chk_cnt++; if (nmi_n !== 1'b1) $display("FAIL rst_nmi got=%b exp=1", nmi_n); else pass_cnt++;
      chk_cnt++; if ({main_flag, snd_flag, fifo_full} !== 3'b000)
         $display("FAIL rst_flags got=%b exp=000", {main_flag, snd_flag, fifo_full}); else pass_cnt++;
      chk_cnt++; if (main_dout !== 8'h00) $display("FAIL rst_dout got=%h exp=00", main_dout); else pass_cnt++;
      rst_n = 1'b1;
      tick();
      snd_addr = 2'd0;
      #1;
      chk_cnt++; if (snd_dout !== 8'hFF) $display("FAIL rst_rd0 got=%h exp=FF", snd_dout); else pass_cnt++;
      snd_addr = 2'd1;
      #1;
      chk_cnt++; if (snd_dout !== 8'h00) $display("FAIL rst_status got=%h exp=00", snd_dout); else pass_cnt++;
      tick();
   endtask

   task automatic test_fifo_order();
      logic [7:0] d, e;
      int l0;
      l0 = nmi_low_total;
      push(8'h12);
      push(8'h34);
      chk_cnt++; if (snd_flag !== 1'b1) $display("FAIL order_pending got=%b exp=1", snd_flag); else pass_cnt++;
      for (int i = 0; i < 2; i++) begin
         e = model_read(2'd0);
         snd_read(2'd0, 1'b0, 8'h00, d);
         chk_cnt++; if (d !== e) $display("FAIL order_rd%0d got=%h exp=%h", i, d, e); else pass_cnt++;
      end
      chk_cnt++; if (snd_flag !== 1'b0) $display("FAIL order_empty got=%b exp=0", snd_flag); else pass_cnt++;
      tick();
      chk_cnt++; if (nmi_low_total !== l0)
         $display("FAIL order_no_nmi got=%0d exp=0", nmi_low_total - l0); else pass_cnt++;
   endtask

   task automatic test_nmi();
      logic [7:0] d, e;
      int l0;
      bit seen;
      snd_write(2'd1, 8'h00, 1'b0);
      l0 = nmi_low_total;
      push(8'hA5);
      repeat (40) tick();
      chk_cnt++; if (nmi_low_total - l0 !== NMI_W)
         $display("FAIL nmi_len1 got=%0d exp=%0d", nmi_low_total - l0, NMI_W); else pass_cnt++;
      chk_cnt++; if (nmi_n !== 1'b1) $display("FAIL nmi_wait_hi got=%b exp=1", nmi_n); else pass_cnt++;
      e = model_read(2'd0);
      snd_read(2'd0, 1'b0, 8'h00, d);
      chk_cnt++; if (d !== e) $display("FAIL nmi_rd got=%h exp=%h", d, e); else pass_cnt++;
      l0 = nmi_low_total;
      repeat (30) tick();
      chk_cnt++; if (nmi_low_total !== l0)
         $display("FAIL nmi_idle_quiet got=%0d exp=0", nmi_low_total - l0); else pass_cnt++;
      push(8'h3C);
      repeat (40) tick();
      chk_cnt++; if (nmi_low_total - l0 !== NMI_W)
         $display("FAIL nmi_len2 got=%0d exp=%0d", nmi_low_total - l0, NMI_W); else pass_cnt++;
      snd_read(2'd0, 1'b0, 8'h00, d);
      // disabling mid-pulse must end it early
      l0 = nmi_low_total;
      push(8'h11);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (nmi_n === 1'b0) seen = 1'b1;
      end
      chk_cnt++; if (!seen) $display("FAIL nmi_start_timeout got=none exp=low"); else pass_cnt++;
      tick();
      snd_write(2'd2, 8'h00, 1'b0);
      chk_cnt++; if (nmi_n !== 1'b1) $display("FAIL nmi_off_hi got=%b exp=1", nmi_n); else pass_cnt++;
      chk_cnt++; if (nmi_low_total - l0 >= NMI_W)
         $display("FAIL nmi_off_short got=%0d exp<%0d", nmi_low_total - l0, NMI_W); else pass_cnt++;
      l0 = nmi_low_total;
      repeat (30) tick();
      chk_cnt++; if (nmi_low_total !== l0)
         $display("FAIL nmi_off_quiet got=%0d exp=0", nmi_low_total - l0); else pass_cnt++;
      e = model_read(2'd0);
      snd_read(2'd0, 1'b0, 8'h00, d);
      chk_cnt++; if (d !== e) $display("FAIL nmi_off_rd got=%h exp=%h", d, e); else pass_cnt++;
   endtask

   task automatic test_overflow();
      logic [7:0] d, e;
      for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom));
      chk_cnt++; if (fifo_full !== 1'b1) $display("FAIL ovf_full got=%b exp=1", fifo_full); else pass_cnt++;
      e = model_read(2'd1);
      snd_read(2'd1, 1'b0, 8'h00, d);
      chk_cnt++; if (d !== e || d[2] !== 1'b1) $display("FAIL ovf_status got=%h exp=%h", d, e); else pass_cnt++;
      snd_write(2'd3, 8'h00, 1'b0);
      e = model_read(2'd1);
      snd_read(2'd1, 1'b0, 8'h00, d);
      chk_cnt++; if (d !== e || d[2] !== 1'b0) $display("FAIL ovf_clear got=%h exp=%h", d, e); else pass_cnt++;
      for (int i = 0; i < DEPTH; i++) begin
         e = model_read(2'd0);
         snd_read(2'd0, 1'b0, 8'h00, d);
         chk_cnt++; if (d !== e) $display("FAIL ovf_drain%0d got=%h exp=%h", i, d, e); else pass_cnt++;
      end
      chk_cnt++; if (snd_flag !== 1'b0) $display("FAIL ovf_empty got=%b exp=0", snd_flag); else pass_cnt++;
   endtask

   task automatic test_full_pushpop();
      logic [7:0] d, e, nb;
      for (int i = 0; i < DEPTH; i++) push(8'($urandom));
      nb = 8'($urandom);
      e = model_read(2'd0);
      snd_read(2'd0, 1'b1, nb, d);
      chk_cnt++; if (d !== e) $display("FAIL pp_rd got=%h exp=%h", d, e); else pass_cnt++;
      chk_cnt++; if (fifo_full !== 1'b1) $display("FAIL pp_full got=%b exp=1", fifo_full); else pass_cnt++;
      e = model_read(2'd1);
      snd_read(2'd1, 1'b0, 8'h00, d);
      chk_cnt++; if (d !== e || d[2] !== 1'b0) $display("FAIL pp_no_ovf got=%h exp=%h", d, e); else pass_cnt++;
      for (int i = 0; i < DEPTH; i++) begin
         e = model_read(2'd0);
         snd_read(2'd0, 1'b0, 8'h00, d);
         chk_cnt++; if (d !== e) $display("FAIL pp_drain%0d got=%h exp=%h", i, d, e); else pass_cnt++;
      end
      chk_cnt++; if (d !== nb) $display("FAIL pp_last got=%h exp=%h", d, nb); else pass_cnt++;
   endtask

   task automatic test_wr_vs_mainrd();
      main_read();
      chk_cnt++; if (main_flag !== 1'b0) $display("FAIL mrd_clear got=%b exp=0", main_flag); else pass_cnt++;
      snd_write(2'd0, 8'h5A, 1'b1);
      chk_cnt++; if (main_dout !== 8'h5A) $display("FAIL wr_win_dout got=%h exp=5A", main_dout); else pass_cnt++;
      chk_cnt++; if (main_flag !== 1'b1) $display("FAIL wr_win_flag got=%b exp=1", main_flag); else pass_cnt++;
      main_read();
      chk_cnt++; if (main_flag !== 1'b0) $display("FAIL mrd_after got=%b exp=0", main_flag); else pass_cnt++;
   endtask

   task automatic test_random();
      logic [7:0] d, e, b;
      logic [1:0] a;
      int op;
      for (int it = 0; it < 150; it++) begin
         op = $urandom_range(0, 6);
         b = 8'($urandom);
         case (op)
            0, 1: push(b);
            2: begin
               e = model_read(2'd0);
               snd_read(2'd0, 1'($urandom_range(0, 1)), b, d);
               chk_cnt++; if (d !== e) $display("FAIL rnd_rd0 it=%0d got=%h exp=%h", it, d, e); else pass_cnt++;
            end
            3: begin
               a = 2'($urandom_range(1, 3));
               e = model_read(a);
               snd_read(a, 1'b0, 8'h00, d);
               chk_cnt++; if (d !== e) $display("FAIL rnd_rd%0d it=%0d got=%h exp=%h", a, it, d, e); else pass_cnt++;
            end
            4: snd_write(2'd0, b, 1'($urandom_range(0, 1)));
            5: main_read();
            default: snd_write(2'd3, 8'h00, 1'b0);
         endcase
         chk_cnt++; if (snd_flag !== (q_m.size() != 0))
            $display("FAIL rnd_sflag it=%0d got=%b exp=%b", it, snd_flag, q_m.size() != 0); else pass_cnt++;
         chk_cnt++; if (fifo_full !== (q_m.size() == DEPTH))
            $display("FAIL rnd_full it=%0d got=%b exp=%b", it, fifo_full, q_m.size() == DEPTH); else pass_cnt++;
         chk_cnt++; if (main_flag !== mflag_m || main_dout !== mdout_m)
            $display("FAIL rnd_main it=%0d got=%b/%h exp=%b/%h", it, main_flag, main_dout, mflag_m, mdout_m);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid_pulse();
      logic [7:0] d;
      bit seen;
      int l0;
      snd_write(2'd1, 8'h00, 1'b0);
      push(8'h77);
      push(8'h78);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (nmi_n === 1'b0) seen = 1'b1;
      end
      chk_cnt++; if (!seen) $display("FAIL rstp_start_timeout got=none exp=low"); else pass_cnt++;
      repeat (3) tick();
      snd_addr = 2'd0;
      rst_n = 1'b0;
      #1;
      chk_cnt++; if (nmi_n !== 1'b1) $display("FAIL rstp_nmi got=%b exp=1", nmi_n); else pass_cnt++;
      chk_cnt++; if ({main_flag, snd_flag, fifo_full} !== 3'b000)
         $display("FAIL rstp_flags got=%b exp=000", {main_flag, snd_flag, fifo_full}); else pass_cnt++;
      chk_cnt++; if (snd_dout !== 8'hFF) $display("FAIL rstp_rd0_async got=%h exp=FF", snd_dout); else pass_cnt++;
      q_m.delete();
      ovf_m = 1'b0;
      mflag_m = 1'b0;
      mdout_m = 8'h00;
      tick();
      rst_n = 1'b1;
      tick();
      l0 = nmi_low_total;
      snd_read(2'd0, 1'b0, 8'h00, d);
      chk_cnt++; if (d !== 8'hFF) $display("FAIL rstp_rd0 got=%h exp=FF", d); else pass_cnt++;
      repeat (20) tick();
      chk_cnt++; if (nmi_low_total !== l0)
         $display("FAIL rstp_quiet got=%0d exp=0", nmi_low_total - l0); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_fifo_order();
      test_nmi();
      test_overflow();
      test_full_pushpop();
      test_wr_vs_mainrd();
      test_random();
      test_reset_mid_pulse();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/jtbubl_sndcomm.md
JTBUBL_SNDCOMM -- requirements
Module: jtbubl_sndcomm

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter NMI_W, default 16, NMI low-pulse length in clk cycles.
REQ-003 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 main_wr  input  1  one-cycle strobe, main CPU pushes a command.
REQ-006 main_din  input  8  command byte.
REQ-007 main_rd  input  1  one-cycle strobe, main CPU has read the reply.
REQ-008 main_dout  output  8  reply latch.
REQ-009 main_flag  output  1  reply latch full.
REQ-010 snd_flag  output  1  command pending (FIFO not empty).
REQ-011 fifo_full  output  1  FIFO holds DEPTH entries.
REQ-012 snd_cs  input  1  sound Z80 I/O window select (held for a whole access).
REQ-013 snd_rd_n, snd_wr_n  input  1 each  Z80 strobes, active low.
REQ-014 snd_addr  input  2  register select.
REQ-015 snd_din  input  8  Z80 write data.
REQ-016 snd_dout  output  8  Z80 read data, combinational from snd_addr and state.
REQ-017 nmi_n  output  1  NMI to sound Z80, active low.

Function
REQ-018 SHALL detect a sound access start as the first clk with snd_cs and a strobe low (registered previous-state edge detect); write side effects occur once per access, at that cycle.
REQ-019 SHALL map addr 0: read = FIFO head (8'hFF if empty); write = load main_dout, set main_flag.
REQ-020 SHALL map addr 1: read = {5'b0, ovf, main_flag, snd_flag}; write = nmi_en<=1.
REQ-021 SHALL map addr 2: read = 8'hFF; write = nmi_en<=0.
REQ-022 SHALL map addr 3: read = 8'hFF; write = clear sticky ovf.
REQ-023 SHALL pop the FIFO in the clk after an addr-0 read access ends (snd_cs or snd_rd_n released), so snd_dout stays stable through the access; an empty-FIFO read does not pop.
REQ-024 SHALL push main_din on main_wr when not full; when full and no pop in the same cycle the byte is dropped and ovf set.
REQ-025 SHALL, on simultaneous push and pop, perform both; occupancy unchanged; a push when full with concurrent pop is accepted.
REQ-026 SHALL wrap read/write pointers modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-027 SHALL clear main_flag on main_rd; a same-cycle sound addr-0 write wins (new data, flag stays 1).
REQ-028 NMI FSM states IDLE, PULSE, WAIT.
REQ-029 IDLE -> PULSE when nmi_en and snd_flag; nmi_n=0 in PULSE for exactly NMI_W clks, then -> WAIT with nmi_n=1.
REQ-030 WAIT -> IDLE on a FIFO pop; re-trigger from IDLE next cycle if still pending and enabled.
REQ-031 Clearing nmi_en in PULSE or WAIT SHALL force IDLE and nmi_n=1 the next cycle.
REQ-032 Outputs snd_flag, fifo_full, main_flag, nmi_n SHALL be registered.

Reset
REQ-033 On rst_n low: FIFO empty, pointers 0, ovf=0, nmi_en=0, FSM IDLE, nmi_n=1, main_dout=8'h00, main_flag=0, snd_flag=0, fifo_full=0; asynchronous assert, release on clk.
REQ-034 Reset mid-pulse SHALL release nmi_n immediately; queued commands are lost.

Structure
REQ-035 Register addresses and FSM state encodings SHALL live in shared package jtbubl_pkg.
REQ-036 FIFO storage/pointers SHALL be sub-module jtbubl_sndcomm_fifo; FSM and register decode stay in top.

Verification
REQ-037 Push 8'h12,8'h34 with nmi_en=0; two addr-0 reads -> 8'h12 then 8'h34, snd_flag 0 after second pop, nmi_n never low.
REQ-038 Write addr1, push 8'hA5 -> nmi_n low exactly 16 clks; pop -> IDLE; second push -> new 16-clk pulse.
REQ-039 Push 5 bytes with DEPTH=4 -> fifo_full=1, fifth dropped, status bit2=1; addr-3 write clears it.
REQ-040 Full FIFO, main_wr and pop same cycle -> byte accepted, fifo_full stays 1, order preserved.
REQ-041 Sound writes 8'h5A to addr 0 same cycle as main_rd -> main_dout=8'h5A, main_flag=1.
REQ-042 Assert rst_n low during NMI pulse -> nmi_n=1 at once, all flags 0, addr-0 read returns 8'hFF.
